// File: rtl/packet_pkg.sv
// Shared command/error codes and FSM state encoding for the host-command frame decoder.
package packet_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h00;
  localparam logic [7:0] CMD_READ  = 8'h01;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_CMD     = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_CHK     = 2'b11;

  typedef enum logic [2:0] {
    S_CMD   = 3'd0,
    S_ADDR  = 3'd1,
    S_DATA  = 3'd2,
    S_CHK   = 3'd3,
    S_OUT   = 3'd4,
    S_FLUSH = 3'd5
  } state_t;

endpackage

// File: rtl/gap_timer.sv
// Counts consecutive idle cycles; expired flags the idle cycle on which the count reaches TIMEOUT_CYCLES.
module gap_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 300
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  // Combinational so the owner can act on the same idle cycle the count hits the limit.
  assign expired = enable && (count == LAST);

endmodule

// File: rtl/packet_decoder.sv
// Host-command frame decoder: command, little-endian address, optional write data and XOR checksum,
// one result per frame over valid/ready, with timeout detection and flush-until-idle resync.
module packet_decoder
  import packet_pkg::*;
#(
  parameter int unsigned ADDR_BYTES     = 2,
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned DATA_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 300,
  parameter bit          CHECKSUM_EN    = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              i_byte,
  input  logic                    i_byte_valid,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [7:0]              o_command,
  output logic [ADDR_WIDTH-1:0]   o_address,
  output logic [8*DATA_BYTES-1:0] o_data,
  output logic                    o_readwrite,
  output logic [1:0]              o_error,
  output logic                    o_overrun
);

  localparam int unsigned MAXB = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
  localparam int unsigned IW   = $clog2(MAXB + 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic [7:0]    acc;
  logic          in_frame;
  logic          gap_enable;
  logic          gap_clear;
  logic          expired;

  assign in_frame   = (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign gap_enable = !i_byte_valid && (in_frame || (state == S_FLUSH));
  assign gap_clear  = i_byte_valid || !(in_frame || (state == S_FLUSH));
  assign o_valid    = (state == S_OUT);

  gap_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_gap_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (gap_clear),
    .enable (gap_enable),
    .expired(expired)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_CMD;
      idx         <= '0;
      acc         <= '0;
      o_command   <= '0;
      o_address   <= '0;
      o_data      <= '0;
      o_readwrite <= 1'b0;
      o_error     <= ERR_OK;
      o_overrun   <= 1'b0;
    end else begin
      o_overrun <= i_byte_valid && (state == S_OUT);
      case (state)
        S_CMD: begin
          if (i_byte_valid) begin
            o_command   <= i_byte;
            o_address   <= '0;
            o_data      <= '0;
            acc         <= i_byte;
            idx         <= '0;
            o_readwrite <= (i_byte == CMD_READ);
            if ((i_byte == CMD_WRITE) || (i_byte == CMD_READ)) begin
              o_error <= ERR_OK;
              state   <= S_ADDR;
            end else begin
              o_error <= ERR_CMD;
              state   <= S_OUT;
            end
          end
        end
        S_ADDR: begin
          if (i_byte_valid) begin
            // Bit-wise placement drops received address bits above ADDR_WIDTH.
            for (int unsigned b = 0; b < ADDR_WIDTH; b++) begin
              if (idx == IW'(b / 8)) o_address[b] <= i_byte[b % 8];
            end
            acc <= acc ^ i_byte;
            if (idx == IW'(ADDR_BYTES - 1)) begin
              idx <= '0;
              if (!o_readwrite)     state <= S_DATA;
              else if (CHECKSUM_EN) state <= S_CHK;
              else                  state <= S_OUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (expired) begin
            o_error <= ERR_TIMEOUT;
            o_data  <= '0;
            state   <= S_OUT;
          end
        end
        S_DATA: begin
          if (i_byte_valid) begin
            for (int unsigned k = 0; k < DATA_BYTES; k++) begin
              if (idx == IW'(k)) o_data[8*k +: 8] <= i_byte;
            end
            acc <= acc ^ i_byte;
            if (idx == IW'(DATA_BYTES - 1)) begin
              idx   <= '0;
              state <= CHECKSUM_EN ? S_CHK : S_OUT;
            end else begin
              idx <= idx + 1'b1;
            end
          end else if (expired) begin
            o_error <= ERR_TIMEOUT;
            o_data  <= '0;
            state   <= S_OUT;
          end
        end
        S_CHK: begin
          if (i_byte_valid) begin
            if (i_byte == acc) begin
              o_error <= ERR_OK;
            end else begin
              o_error <= ERR_CHK;
              o_data  <= '0;
            end
            state <= S_OUT;
          end else if (expired) begin
            o_error <= ERR_TIMEOUT;
            o_data  <= '0;
            state   <= S_OUT;
          end
        end
        S_OUT: begin
          if (i_ready) state <= (o_error == ERR_OK) ? S_CMD : S_FLUSH;
        end
        S_FLUSH: begin
          if (expired) state <= S_CMD;
        end
        default: state <= S_CMD;
      endcase
    end
  end

endmodule
